dcache_refill_ctrl: RTL and testbench

Miss handler and line-refill controller for the data cache. It watches the registered tag-lookup result (hit, valid, lookup address) and, on a miss, stalls the CPU. It then fetches the 32-byte line from memory as an 8-beat incrementing read burst and writes each beat into the data bank. Only after all eight beats are stored does it write the tag entry with valid set, so a partially filled line is never visible as valid. It sits between the tag/data arrays and the bus interface, and is the writer side of the tag array's wen/wdata port.

---
 rtl/dcache_refill_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_dcache_refill_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_refill_ctrl
//
// Miss handler and line-refill controller for the data cache.
//
// It watches the registered tag-lookup result. On a miss it stalls the CPU and
// fetches the whole line as one incrementing read burst (LINE_WORDS beats).
// Each beat is written straight into the data bank. The tag entry, with its
// valid bit set, is written only after the last beat has been stored, so a
// partly filled line never looks valid. One cycle after the tag write, the
// word the CPU asked for (the critical word) is returned on resp_*.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   tag_ready_i               tag array has finished its reset sweep
//   lookup_valid_i            access in the tag-compare stage this cycle
//   lookup_addr_i [31:0]      address aligned with tag_hit_i / tag_valid_i
//   tag_hit_i, tag_valid_i    tag compare result and stored valid bit
//   cpu_stall_o               hold the pipeline
//   mem_arvalid_o             burst request valid
//   mem_araddr_o  [31:0]      line-aligned burst address
//   mem_arlen_o   [7:0]       burst length - 1 (constant)
//   mem_arready_i             burst request accepted
//   mem_rvalid_i              read beat valid
//   mem_rdata_i   [31:0]      read beat data
//   mem_rready_o              read beat accept
//   data_wen_o                data-bank word write strobe
//   data_waddr_o  [9:0]       {set index, word in line}
//   data_wdata_o  [31:0]      word to write (the current read beat)
//   tag_wen_o                 tag-array write strobe
//   tag_waddr_o   [31:0]      latched miss address (tag array uses the index)
//   tag_wdata_o   [20:0]      {valid=1, tag of the latched address}
//   resp_valid_o              one-cycle pulse: refill done, resp_data_o valid
//   resp_data_o   [31:0]      critical word of the missed access
// -----------------------------------------------------------------------------
module dcache_refill_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int TAG_W      = 20,
    parameter int INDEX_W    = 7
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       tag_ready_i,
    input  logic                       lookup_valid_i,
    input  logic [31:0]                lookup_addr_i,
    input  logic                       tag_hit_i,
    input  logic                       tag_valid_i,

    output logic                       cpu_stall_o,

    output logic                       mem_arvalid_o,
    output logic [31:0]                mem_araddr_o,
    output logic [7:0]                 mem_arlen_o,
    input  logic                       mem_arready_i,
    input  logic                       mem_rvalid_i,
    input  logic [31:0]                mem_rdata_i,
    output logic                       mem_rready_o,

    output logic                       data_wen_o,
    output logic [INDEX_W+$clog2(LINE_WORDS)-1:0] data_waddr_o,
    output logic [31:0]                data_wdata_o,

    output logic                       tag_wen_o,
    output logic [31:0]                tag_waddr_o,
    output logic [TAG_W:0]             tag_wdata_o,

    output logic                       resp_valid_o,
    output logic [31:0]                resp_data_o
);

    // Address field layout: [tag | index | word | byte]
    localparam int CNT_W   = $clog2(LINE_WORDS);
    localparam int WORD_LO = 2;
    localparam int WORD_HI = WORD_LO + CNT_W - 1;
    localparam int IDX_LO  = WORD_HI + 1;
    localparam int IDX_HI  = IDX_LO + INDEX_W - 1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_AR,
        S_R,
        S_TAGW,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;     // word of the line the next beat fills
    logic [31:0]        addr_q,  addr_d;    // latched miss address
    logic [31:0]        resp_q,  resp_d;    // captured critical word

    logic miss;
    logic beat;

    assign miss = lookup_valid_i & tag_ready_i & ~(tag_hit_i & tag_valid_i);
    assign beat = (state_q == S_R) & mem_rvalid_i;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every register here is reset; they are few and flat, so there is
    // no memory-sized array whose reset would cost anything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            addr_q  <= '0;
            resp_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            resp_q  <= resp_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: hold-current defaults first, so no path leaves a latch behind.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        resp_d  = resp_q;

        unique case (state_q)
            S_INIT: begin
                if (tag_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (miss) begin
                    addr_d  = lookup_addr_i;
                    cnt_d   = '0;
                    state_d = S_AR;
                end
            end

            S_AR: begin
                if (mem_arready_i) begin
                    state_d = S_R;
                end
            end

            S_R: begin
                if (mem_rvalid_i) begin
                    // Counter wraps to 0 on the last beat, as the FSM leaves R.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == addr_q[WORD_HI:WORD_LO]) begin
                        resp_d = mem_rdata_i;
                    end
                    // No rlast: the beat count alone ends the burst.
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_TAGW;
                    end
                end
            end

            S_TAGW: begin
                state_d = S_DONE;
            end

            S_DONE: begin
                // A lookup in this cycle is not acted on; the pipeline replays.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Strobes are masked by rst so a reset mid-burst withdraws the bus request
    // and beat acceptance in the same cycle, not one edge later.
    always_comb begin
        cpu_stall_o   = 1'b0;
        mem_arvalid_o = 1'b0;
        mem_rready_o  = 1'b0;
        data_wen_o    = 1'b0;
        tag_wen_o     = 1'b0;
        resp_valid_o  = 1'b0;

        if (!rst) begin
            cpu_stall_o   = ((state_q == S_IDLE) & miss) |
                            (state_q == S_AR) | (state_q == S_R) | (state_q == S_TAGW);
            mem_arvalid_o = (state_q == S_AR);
            mem_rready_o  = (state_q == S_R);
            data_wen_o    = beat;
            tag_wen_o     = (state_q == S_TAGW);
            resp_valid_o  = (state_q == S_DONE);
        end
    end

    // Request fields come from the latched address, so they cannot move while
    // arvalid waits for arready.
    assign mem_araddr_o = {addr_q[31:IDX_LO], {IDX_LO{1'b0}}};
    assign mem_arlen_o  = 8'(LINE_WORDS - 1);

    // Data-bank write port is zeroed outside a write so idle-bus noise on
    // mem_rdata never shows up on it.
    assign data_waddr_o = data_wen_o ? {addr_q[IDX_HI:IDX_LO], cnt_q} : '0;
    assign data_wdata_o = data_wen_o ? mem_rdata_i : '0;

    assign tag_waddr_o  = addr_q;
    assign tag_wdata_o  = tag_wen_o ? {1'b1, addr_q[31 -: TAG_W]} : '0;

    assign resp_data_o  = resp_q;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_refill_ctrl
//
// Directed bench for the refill controller. The stimulus script also states,
// cycle by cycle, which handshake/strobe outputs must be high; a per-cycle
// compare process checks them and checks every data-bank write, tag write and
// response against a queue of expected writes computed from the miss address.
// A few literal values (addresses, critical words, latencies) are checked by
// the main sequence after each refill.
// -----------------------------------------------------------------------------
module tb_dcache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tag_ready_i;
    logic        lookup_valid_i;
    logic [31:0] lookup_addr_i;
    logic        tag_hit_i;
    logic        tag_valid_i;
    logic        cpu_stall_o;
    logic        mem_arvalid_o;
    logic [31:0] mem_araddr_o;
    logic [7:0]  mem_arlen_o;
    logic        mem_arready_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_rready_o;
    logic        data_wen_o;
    logic [9:0]  data_waddr_o;
    logic [31:0] data_wdata_o;
    logic        tag_wen_o;
    logic [31:0] tag_waddr_o;
    logic [20:0] tag_wdata_o;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;

    always #5 clk = ~clk;

    dcache_refill_ctrl #(.LINE_WORDS(8), .TAG_W(20), .INDEX_W(7)) dut (
        .clk            (clk),
        .rst            (rst),
        .tag_ready_i    (tag_ready_i),
        .lookup_valid_i (lookup_valid_i),
        .lookup_addr_i  (lookup_addr_i),
        .tag_hit_i      (tag_hit_i),
        .tag_valid_i    (tag_valid_i),
        .cpu_stall_o    (cpu_stall_o),
        .mem_arvalid_o  (mem_arvalid_o),
        .mem_araddr_o   (mem_araddr_o),
        .mem_arlen_o    (mem_arlen_o),
        .mem_arready_i  (mem_arready_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_rready_o   (mem_rready_o),
        .data_wen_o     (data_wen_o),
        .data_waddr_o   (data_waddr_o),
        .data_wdata_o   (data_wdata_o),
        .tag_wen_o      (tag_wen_o),
        .tag_waddr_o    (tag_waddr_o),
        .tag_wdata_o    (tag_wdata_o),
        .resp_valid_o   (resp_valid_o),
        .resp_data_o    (resp_data_o)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory contents: each word is its own byte address scrambled by a constant.
    function automatic logic [31:0] beat_data(input logic [31:0] a, input int k);
        logic [2:0] w;
        w = 3'(k);
        return {a[31:5], w, 2'b00} ^ 32'hA5A5_0000;
    endfunction

    // ---------------------------------------------------------------- model
    logic        exp_stall, exp_arvalid, exp_rready, exp_tagw, exp_resp;
    logic [31:0] exp_addr;
    logic [41:0] wq[$];           // expected data-bank writes {waddr, wdata}
    bit          chk_en = 1'b0;

    int          cyc = 0;
    int          miss_cyc, resp_cyc;
    int          wen_cnt, tagw_cnt;
    logic [9:0]  first_waddr, last_waddr;
    logic [31:0] last_araddr, last_resp;
    logic [20:0] last_tagw;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            logic [41:0] ent;
            check("cpu_stall",   32'(cpu_stall_o),   32'(exp_stall));
            check("mem_arvalid", 32'(mem_arvalid_o), 32'(exp_arvalid));
            check("mem_rready",  32'(mem_rready_o),  32'(exp_rready));
            check("data_wen",    32'(data_wen_o),    32'(exp_rready & mem_rvalid_i));
            check("tag_wen",     32'(tag_wen_o),     32'(exp_tagw));
            check("resp_valid",  32'(resp_valid_o),  32'(exp_resp));

            if (mem_arvalid_o) begin
                check("mem_araddr", mem_araddr_o, {exp_addr[31:5], 5'b0});
                check("mem_arlen",  32'(mem_arlen_o), 32'd7);
                last_araddr = mem_araddr_o;
            end
            if (data_wen_o) begin
                if (wq.size() == 0) begin
                    check("data_wen_unexpected", 32'(data_wen_o), 32'd0);
                end else begin
                    ent = wq.pop_front();
                    check("data_waddr", 32'(data_waddr_o), 32'(ent[41:32]));
                    check("data_wdata", data_wdata_o, ent[31:0]);
                end
                if (wen_cnt == 0) first_waddr = data_waddr_o;
                last_waddr = data_waddr_o;
                wen_cnt++;
            end
            if (tag_wen_o) begin
                check("tag_before_last_beat", 32'(wq.size()), 32'd0);
                check("tag_waddr", tag_waddr_o, exp_addr);
                check("tag_wdata", 32'(tag_wdata_o), 32'({1'b1, exp_addr[31:12]}));
                last_tagw = tag_wdata_o;
                tagw_cnt++;
            end
            if (resp_valid_o) begin
                check("resp_data", resp_data_o, beat_data(exp_addr, int'(exp_addr[4:2])));
                last_resp = resp_data_o;
                resp_cyc  = cyc;
            end
        end
    end

    // ---------------------------------------------------------------- driver
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic s, input logic ar, input logic r,
                           input logic t, input logic rv);
        exp_stall   = s;
        exp_arvalid = ar;
        exp_rready  = r;
        exp_tagw    = t;
        exp_resp    = rv;
    endtask

    task automatic check_reset_data();
        check("rst_araddr",     mem_araddr_o,       32'd0);
        check("rst_arlen",      32'(mem_arlen_o),   32'd7);
        check("rst_tag_waddr",  tag_waddr_o,        32'd0);
        check("rst_tag_wdata",  32'(tag_wdata_o),   32'd0);
        check("rst_resp_data",  resp_data_o,        32'd0);
        check("rst_data_waddr", 32'(data_waddr_o),  32'd0);
        check("rst_data_wdata", data_wdata_o,       32'd0);
    endtask

    // One miss at address a. Beats are back-to-back unless gap is set, in
    // which case every beat is followed by an rvalid=0 cycle. With fewer than
    // 8 beats, reset is asserted right after the last one.
    task automatic refill(input logic [31:0] a, input logic h, input logic v,
                          input int ar_delay, input bit gap, input int nbeats);
        int beats;
        bit toggle;
        beats    = 0;
        toggle   = 1'b0;
        wen_cnt  = 0;
        tagw_cnt = 0;

        lookup_valid_i = 1'b1;
        lookup_addr_i  = a;
        tag_hit_i      = h;
        tag_valid_i    = v;
        exp_addr       = a;
        miss_cyc       = cyc;
        for (int k = 0; k < 8; k++) begin
            wq.push_back({a[11:5], 3'(k), beat_data(a, k)});
        end
        set_exp(1, 0, 0, 0, 0);
        next_cycle();

        // A missing lookup stays on the inputs during the refill; it must be ignored.
        lookup_addr_i = 32'hDEAD_BEE0;
        tag_hit_i     = 1'b0;
        tag_valid_i   = 1'b0;
        repeat (ar_delay) begin
            mem_arready_i = 1'b0;
            set_exp(1, 1, 0, 0, 0);
            next_cycle();
        end
        mem_arready_i = 1'b1;
        set_exp(1, 1, 0, 0, 0);
        next_cycle();

        mem_arready_i = 1'b0;
        set_exp(1, 0, 1, 0, 0);
        while (beats < nbeats) begin
            if (gap && toggle) begin
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = 32'h0BAD_0BAD;
            end else begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = beat_data(a, beats);
                beats++;
            end
            toggle = ~toggle;
            next_cycle();
        end

        mem_rvalid_i   = 1'b0;
        mem_rdata_i    = 32'h1234_5678;
        lookup_valid_i = 1'b0;
        if (nbeats < 8) begin
            rst = 1'b1;
            wq.delete();
            set_exp(0, 0, 0, 0, 0);
            next_cycle();
            rst = 1'b0;
        end else begin
            set_exp(1, 0, 0, 1, 0);
            next_cycle();
            set_exp(0, 0, 0, 0, 1);
            next_cycle();
            set_exp(0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        tag_ready_i    = 1'b0;
        lookup_valid_i = 1'b1;
        lookup_addr_i  = 32'h1111_1100;
        tag_hit_i      = 1'b0;
        tag_valid_i    = 1'b0;
        mem_arready_i  = 1'b0;
        mem_rvalid_i   = 1'b0;
        mem_rdata_i    = 32'h1234_5678;
        set_exp(0, 0, 0, 0, 0);
        exp_addr = '0;
        #1;
        chk_en = 1'b1;
        next_cycle();
        next_cycle();
        check_reset_data();

        // Boot: tag array still sweeping, misses on the inputs must be ignored.
        rst = 1'b0;
        repeat (128) next_cycle();
        lookup_valid_i = 1'b0;
        tag_ready_i    = 1'b1;
        next_cycle();               // INIT -> IDLE
        next_cycle();

        // Hit: nothing happens.
        lookup_valid_i = 1'b1;
        lookup_addr_i  = 32'h1000_0024;
        tag_hit_i      = 1'b1;
        tag_valid_i    = 1'b1;
        repeat (4) next_cycle();
        lookup_valid_i = 1'b0;
        next_cycle();

        // Cold miss, fastest bus.
        refill(32'h8000_1234, 1'b0, 1'b0, 0, 1'b0, 8);
        check("cold_araddr",     last_araddr,        32'h8000_1220);
        check("cold_first_wadr", 32'(first_waddr),  32'h088);
        check("cold_last_wadr",  32'(last_waddr),   32'h08F);
        check("cold_wen_count",  32'(wen_cnt),      32'd8);
        check("cold_tag_wdata",  32'(last_tagw),    32'h0018_0001);
        check("cold_resp_data",  last_resp,          32'h25A5_1234);
        check("cold_latency",    32'(resp_cyc - miss_cyc), 32'd11);
        next_cycle();

        // Throttled: arready 3 cycles late, a gap after every beat.
        refill(32'h0000_0FFC, 1'b0, 1'b1, 3, 1'b1, 8);
        check("thr_wen_count",   32'(wen_cnt),      32'd8);
        check("thr_tagw_count",  32'(tagw_cnt),     32'd1);
        check("thr_last_wadr",   32'(last_waddr),   32'h3FF);
        check("thr_resp_data",   last_resp,          32'hA5A5_0FFC);
        check("thr_latency",     32'(resp_cyc - miss_cyc), 32'd21);
        next_cycle();

        // Valid line with the wrong tag, same index as the cold miss.
        refill(32'h1234_5234, 1'b0, 1'b1, 0, 1'b0, 8);
        check("wt_first_wadr",   32'(first_waddr),  32'h088);
        check("wt_tag_wdata",    32'(last_tagw),    32'h0011_2345);
        check("wt_resp_data",    last_resp,          32'hB791_5234);
        next_cycle();

        // Reset after 4 beats, then the same miss again from word 0.
        refill(32'h4000_00A8, 1'b1, 1'b0, 1, 1'b0, 4);
        check("abort_wen_count", 32'(wen_cnt),      32'd4);
        check("abort_tagw_count",32'(tagw_cnt),     32'd0);
        check_reset_data();         // back in INIT, registers cleared
        next_cycle();               // INIT -> IDLE
        refill(32'h4000_00A8, 1'b0, 1'b0, 0, 1'b0, 8);
        check("re_first_wadr",   32'(first_waddr),  32'h028);
        check("re_wen_count",    32'(wen_cnt),      32'd8);
        check("re_resp_data",    last_resp,          32'hE5A5_00A8);
        check("re_latency",      32'(resp_cyc - miss_cyc), 32'd11);
        next_cycle();
        next_cycle();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
